// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding and error codes.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_LENGTH  = 2'd3;

endpackage

// File: rtl/uart_boot_loader.sv
// Boot loader: parses a length-prefixed big-endian word image from UART byte strobes
// and writes it word-by-word into memory over a req/ack port.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int                ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0] MAX_WORDS    = ADDR_W'(32'hFFFF),
    parameter int                TIMEOUT_CLKS = 2000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_we,
    input  logic              i_mem_ack,
    output logic              o_busy,
    output logic              o_boot_done,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [31:0]       o_checksum
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS);

    state_t            r_state,      w_state_next;
    logic [31:0]       r_word,       w_word_next;
    logic [1:0]        r_byte_cnt,   w_byte_cnt_next;
    logic [31:0]       r_words_left, w_words_left_next;
    logic              r_hold_valid, w_hold_valid_next;
    logic [7:0]        r_hold_data,  w_hold_data_next;
    logic [TMO_W-1:0]  r_tmo_cnt,    w_tmo_cnt_next;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_next;
    logic [31:0]       r_mem_wdata,  w_mem_wdata_next;
    logic [31:0]       r_checksum,   w_checksum_next;
    logic              r_error,      w_error_next;
    logic [1:0]        r_err_code,   w_err_code_next;

    logic [7:0]        w_take_byte;
    logic [31:0]       w_shifted;
    logic              w_tmo_hit;

    // A byte parked during WRITE always wins over a fresh strobe in DATA.
    assign w_take_byte = r_hold_valid ? r_hold_data : i_rx_data;
    assign w_shifted   = {r_word[23:0], w_take_byte};
    assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_words_left <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_tmo_cnt    <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_checksum   <= '0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_state_next;
            r_word       <= w_word_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_words_left <= w_words_left_next;
            r_hold_valid <= w_hold_valid_next;
            r_hold_data  <= w_hold_data_next;
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_checksum   <= w_checksum_next;
            r_error      <= w_error_next;
            r_err_code   <= w_err_code_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_word_next       = r_word;
        w_byte_cnt_next   = r_byte_cnt;
        w_words_left_next = r_words_left;
        w_hold_valid_next = r_hold_valid;
        w_hold_data_next  = r_hold_data;
        w_tmo_cnt_next    = r_tmo_cnt;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_checksum_next   = r_checksum;
        w_error_next      = r_error;
        w_err_code_next   = r_err_code;

        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_rx_done) begin
                    w_state_next      = ST_LEN;
                    w_word_next       = {24'h0, i_rx_data};
                    w_byte_cnt_next   = 2'd1;
                    w_tmo_cnt_next    = '0;
                    w_hold_valid_next = 1'b0;
                    w_checksum_next   = '0;
                    w_error_next      = 1'b0;
                    w_err_code_next   = ERR_NONE;
                end
            end
            ST_LEN, ST_DATA: begin
                if (r_state == ST_DATA && r_hold_valid) begin
                    w_hold_valid_next = i_rx_done;
                    w_hold_data_next  = i_rx_data;
                end
                if (i_rx_done || (r_state == ST_DATA && r_hold_valid)) begin
                    w_word_next     = w_shifted;
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    w_tmo_cnt_next  = '0;
                    if (r_byte_cnt == 2'd3) begin
                        if (r_state == ST_DATA) begin
                            w_mem_wdata_next = w_shifted;
                            w_state_next     = ST_WRITE;
                        end else if (w_shifted == 32'd0) begin
                            w_state_next = ST_DONE;
                        end else if (w_shifted > 32'(MAX_WORDS)) begin
                            w_state_next    = ST_ERROR;
                            w_error_next    = 1'b1;
                            w_err_code_next = ERR_LENGTH;
                        end else begin
                            w_state_next      = ST_DATA;
                            w_mem_addr_next   = BASE_ADDR;
                            w_words_left_next = w_shifted;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_state_next    = ST_ERROR;
                    w_error_next    = 1'b1;
                    w_err_code_next = ERR_TIMEOUT;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
                end
            end
            ST_WRITE: begin
                if (i_rx_done && r_hold_valid) begin
                    w_state_next      = ST_ERROR;
                    w_error_next      = 1'b1;
                    w_err_code_next   = ERR_OVERRUN;
                    w_hold_valid_next = 1'b0;
                end else begin
                    if (i_rx_done) begin
                        w_hold_valid_next = 1'b1;
                        w_hold_data_next  = i_rx_data;
                    end
                    if (i_mem_ack) begin
                        w_checksum_next   = r_checksum ^ r_mem_wdata;
                        w_mem_addr_next   = r_mem_addr + ADDR_W'(1);
                        w_words_left_next = r_words_left - 32'd1;
                        if (r_words_left == 32'd1) begin
                            w_state_next      = ST_DONE;
                            w_hold_valid_next = 1'b0;
                        end else begin
                            w_state_next = ST_DATA;
                        end
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we    = (r_state == ST_WRITE);
    assign o_busy      = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_WRITE);
    assign o_boot_done = (r_state == ST_DONE);
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;
    assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed image table, stall/overrun, timeout,
// reset-during-write sequences, and random images checked against a word-list model.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        mem_ack = 1'b0;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        boot_done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] checksum;

    uart_boot_loader #(
        .ADDR_W       (24),
        .BASE_ADDR    (24'h0),
        .MAX_WORDS    (24'hFFFF),
        .TIMEOUT_CLKS (100)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_ack   (mem_ack),
        .o_busy      (busy),
        .o_boot_done (boot_done),
        .o_error     (error),
        .o_err_code  (err_code),
        .o_checksum  (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          delay;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_csum;
        int          exp_writes;
    } vec_t;

    wr_t   wr_q[$];
    int    n_checks = 0;
    int    n_err = 0;
    int    ack_delay = 0;
    int    wait_cnt = 0;
    bit    mem_auto = 1'b1;
    int    gap_lo = 5;
    int    gap_hi = 9;

    // Memory side: grants each request after ack_delay extra cycles and logs the write.
    always @(posedge clk) begin
        #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_auto && mem_we) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                wr_q.push_back('{mem_addr, mem_wdata});
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat ($urandom_range(gap_hi, gap_lo)) tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_end(input int limit);
        int i;
        i = 0;
        while (!(boot_done || error) && i < limit) begin
            tick();
            i++;
        end
        chk("load_end_seen", {31'd0, boot_done | error}, 32'd1);
    endtask

    task automatic wait_we(input logic level, input int limit);
        int i;
        i = 0;
        while (mem_we !== level && i < limit) begin
            tick();
            i++;
        end
        chk("mem_we_level", {31'd0, mem_we}, {31'd0, level});
    endtask

    task automatic rearm();
        enable = 1'b0;
        tick();
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_boot_done", {31'd0, boot_done}, 32'd0);
        enable = 1'b1;
        tick();
    endtask

    vec_t        vecs[5];
    logic [31:0] img[$];
    logic [31:0] exp_csum;
    logic [31:0] exp_data;
    int          n_words;

    initial begin
        vecs[0] = '{32'd2,          32'h11223344, 32'hA5A5A5A5, 0,   1'b1, 1'b0, 2'd0, 32'hB48796E1, 2};
        vecs[1] = '{32'd0,          32'h0,        32'h0,        0,   1'b1, 1'b0, 2'd0, 32'h0,        0};
        vecs[2] = '{32'h0001_0000,  32'h0,        32'h0,        0,   1'b0, 1'b1, 2'd3, 32'h0,        0};
        vecs[3] = '{32'd1,          32'hDEADBEEF, 32'h0,        150, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 1};
        vecs[4] = '{32'hFFFF_FFFF,  32'h0,        32'h0,        0,   1'b0, 1'b1, 2'd3, 32'h0,        0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Directed image table
        for (int v = 0; v < 5; v++) begin
            wr_q.delete();
            ack_delay = vecs[v].delay;
            send_word(vecs[v].n);
            if (vecs[v].exp_writes > 0) send_word(vecs[v].w0);
            if (vecs[v].exp_writes > 1) send_word(vecs[v].w1);
            wait_end(400);
            tick();
            chk($sformatf("v%0d_boot_done", v), {31'd0, boot_done}, {31'd0, vecs[v].exp_done});
            chk($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_err_code", v), {30'd0, err_code}, {30'd0, vecs[v].exp_code});
            chk($sformatf("v%0d_checksum", v), checksum, vecs[v].exp_csum);
            chk($sformatf("v%0d_n_writes", v), 32'(wr_q.size()), 32'(vecs[v].exp_writes));
            for (int k = 0; k < wr_q.size() && k < vecs[v].exp_writes; k++) begin
                exp_data = (k == 0) ? vecs[v].w0 : vecs[v].w1;
                chk($sformatf("v%0d_wr%0d_addr", v, k), {8'd0, wr_q[k].addr}, 32'(k));
                chk($sformatf("v%0d_wr%0d_data", v, k), wr_q[k].data, exp_data);
            end
            $display("load v%0d: n=0x%08h writes=%0d done=%0b error=%0b code=%0d csum=0x%08h",
                     v, vecs[v].n, wr_q.size(), boot_done, error, err_code, checksum);
            if (v == 0) begin
                send_byte(8'h55);
                chk("done_ignores_byte_busy", {31'd0, busy}, 32'd0);
                chk("done_ignores_byte_done", {31'd0, boot_done}, 32'd1);
                chk("done_ignores_byte_writes", 32'(wr_q.size()), 32'd2);
            end
            rearm();
        end

        // Stalled write: one byte parked in the holding register and used for word 1
        wr_q.delete();
        ack_delay = 50;
        send_word(32'd2);
        send_word(32'h11223344);
        wait_we(1'b1, 30);
        send_byte(8'hA5);
        chk("stall_we_held", {31'd0, mem_we}, 32'd1);
        chk("stall_no_error", {31'd0, error}, 32'd0);
        wait_we(1'b0, 100);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'hA5);
        wait_end(200);
        tick();
        chk("hold_n_writes", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) chk("hold_wr1_data", wr_q[1].data, 32'hA5A5A5A5);
        chk("hold_checksum", checksum, 32'hB48796E1);
        chk("hold_boot_done", {31'd0, boot_done}, 32'd1);
        $display("load hold: writes=%0d csum=0x%08h", wr_q.size(), checksum);
        rearm();

        // Second byte during the stall overruns the holding register
        wr_q.delete();
        send_word(32'd2);
        send_word(32'h11223344);
        wait_we(1'b1, 30);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("ovr_error", {31'd0, error}, 32'd1);
        chk("ovr_err_code", {30'd0, err_code}, 32'd2);
        chk("ovr_mem_we", {31'd0, mem_we}, 32'd0);
        chk("ovr_n_writes", 32'(wr_q.size()), 32'd0);
        $display("load overrun: error=%0b code=%0d", error, err_code);
        rearm();

        // Inter-byte timeout mid-word, then recovery
        ack_delay = 0;
        send_word(32'd1);
        send_byte(8'hCA);
        send_byte(8'hFE);
        repeat (40) tick();
        chk("tmo_not_yet", {31'd0, error}, 32'd0);
        repeat (100) tick();
        chk("tmo_error", {31'd0, error}, 32'd1);
        chk("tmo_err_code", {30'd0, err_code}, 32'd1);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        $display("load timeout: error=%0b code=%0d", error, err_code);
        rearm();
        wr_q.delete();
        send_byte(8'h00);
        chk("recover_error_cleared", {31'd0, error}, 32'd0);
        chk("recover_code_cleared", {30'd0, err_code}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEF00D);
        wait_end(200);
        tick();
        chk("recover_done", {31'd0, boot_done}, 32'd1);
        chk("recover_checksum", checksum, 32'hCAFEF00D);
        $display("load recover: writes=%0d csum=0x%08h", wr_q.size(), checksum);
        rearm();

        // Asynchronous reset while a write request is pending
        mem_auto = 1'b0;
        send_word(32'd1);
        send_word(32'h12345678);
        wait_we(1'b1, 30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_mem_wdata", mem_wdata, 32'd0);
        chk("arst_mem_addr", {8'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_auto = 1'b1;
        tick();
        tick();
        chk("arst_idle_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h00);
        chk("arst_restart_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("arst_restart_done", {31'd0, boot_done}, 32'd1);
        $display("load reset-restart: done=%0b", boot_done);
        rearm();

        // Random images against the word-list model
        for (int r = 0; r < 10; r++) begin
            n_words = $urandom_range(6, 1);
            ack_delay = $urandom_range(3, 0);
            img.delete();
            wr_q.delete();
            exp_csum = 32'd0;
            for (int k = 0; k < n_words; k++) begin
                img.push_back($urandom);
                exp_csum = exp_csum ^ img[k];
            end
            send_word(32'(n_words));
            for (int k = 0; k < n_words; k++) send_word(img[k]);
            wait_end(300);
            tick();
            chk($sformatf("rnd%0d_n_writes", r), 32'(wr_q.size()), 32'(n_words));
            for (int k = 0; k < wr_q.size() && k < n_words; k++) begin
                chk($sformatf("rnd%0d_wr%0d_addr", r, k), {8'd0, wr_q[k].addr}, 32'(k));
                chk($sformatf("rnd%0d_wr%0d_data", r, k), wr_q[k].data, img[k]);
            end
            chk($sformatf("rnd%0d_checksum", r), checksum, exp_csum);
            chk($sformatf("rnd%0d_boot_done", r), {31'd0, boot_done}, 32'd1);
            chk($sformatf("rnd%0d_error", r), {31'd0, error}, 32'd0);
            $display("load rnd%0d: n=%0d delay=%0d writes=%0d csum=0x%08h",
                     r, n_words, ack_delay, wr_q.size(), checksum);
            rearm();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
